seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial sequence detector and next generation of the fixed-pattern detector. Samples one serial bit `x` per qualified clock and pulses `detector_out` when the last `SEQ_LEN` bits equal the programmed pattern. Adds runtime pattern loading, selectable overlap/non-overlap matching, an input-valid qualifier and a saturating match counter. Sits between a serial bit source and the control or statistics logic that consumes match events.

## Interface
- `SEQ_LEN`, 4: pattern length in bits; legal range 2..32.
- `PATTERN`, 4'b1011: reset/default pattern, `SEQ_LEN` bits; MSB is the first bit received.
- `CNT_W`, 8: width of the match counter.
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `x` in 1: serial data bit.
- `x_valid` in 1: `x` is sampled only when this is 1.
- `overlap_en` in 1: 1 = overlapping matches allowed; 0 = non-overlapping. Sampled every cycle.
- `cfg_load` in 1: loads `cfg_pattern` into the pattern register.
- `cfg_pattern` in SEQ_LEN: new pattern, MSB first.
- `cnt_clr` in 1: clears `match_count`.
- `detector_out` out 1: registered one-cycle match pulse.
- `match_count` out CNT_W: saturating count of matches.

## Operation
- State:
  - `hist[SEQ_LEN-1:0]` shift register.
  - `fill` counter of width clog2(SEQ_LEN+1), saturating at SEQ_LEN.
  - `pat` register.
  - `match_count`.
- Reset (`reset`=1 at an edge):
  - `hist`=0, `fill`=0, `pat`=PATTERN.
  - `detector_out`=0, `match_count`=0.
  - All other inputs ignored that cycle.
- Accepted bit (`x_valid`=1, `cfg_load`=0):
  - nxt = {hist[SEQ_LEN-2:0], x}; `hist` <= nxt.
  - Match condition: nxt == `pat` and (`fill`+1) >= SEQ_LEN.
- On a match:
  - `detector_out` <= 1.
  - `match_count` increments, saturating at 2^CNT_W-1.
  - If `overlap_en`=1, `fill` <= SEQ_LEN.
  - If `overlap_en`=0, `fill` <= 0, so the next match needs SEQ_LEN fresh bits.
- Accepted bit with no match: `fill` <= min(`fill`+1, SEQ_LEN); `detector_out` <= 0.
- `x_valid`=0: `hist` and `fill` hold; `detector_out` <= 0.
- `cfg_load`=1:
  - `pat` <= `cfg_pattern`; `fill` <= 0; `detector_out` <= 0.
  - Any `x` presented that cycle is discarded, even if `x_valid`=1.
- `cnt_clr`=1: `match_count` <= 0. Clear wins over a same-cycle increment, but `detector_out` still pulses for that match.
- No match can occur before SEQ_LEN bits have been accepted since reset, since `cfg_load`, or (non-overlap mode) since the last match.

## Timing
- Latency: the final pattern bit is sampled at edge k. `detector_out` is high from edge k to edge k+1, and `match_count` updates at edge k.
- `detector_out` is always exactly one cycle wide per match. Back-to-back pulses on consecutive cycles are legal in overlap mode, for example with an all-ones pattern.
- `overlap_en` changes take effect on the match decision of the same edge.
- Mid-stream `reset` or `cfg_load`: the partial history is discarded and the next match needs a full SEQ_LEN new bits.
- Counter saturation: at 2^CNT_W-1 the count holds while `detector_out` keeps pulsing.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Defaults (1011), `overlap_en`=1, `x_valid`=1, stream 1,0,1,1,0,1,1 -> `detector_out` pulses after bits 4 and 7; `match_count`=2.
- Same stream with `overlap_en`=0 -> one pulse after bit 4; `match_count`=1. Then stream 1,0,1,1,1,0,1,1 -> pulses after bits 4 and 8.
- `x_valid` gaps: 1,(gap×3),0,1,(gap),1 -> single pulse on the cycle after the final 1; no pulse during gaps.
- `cfg_load` with `cfg_pattern`=0110 after bits 1,0,1 of a 1011 stream, then 0,1,1,0 -> no 1011 match; pulse after the 4th post-load bit. A bit presented in the load cycle is discarded.
- CNT_W=2, pattern 1111, overlap, six 1s -> pulses after bits 4, 5, 6; `match_count` reads 1, 2, 3, then holds 3. `cnt_clr` on the bit-6 match cycle -> count 0 with the pulse still present.
- `reset` asserted after bits 1,0,1, then 1,0,1,1 -> first pulse only after the 4th post-reset bit; all outputs 0 during reset.

Source files
------------

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Serial sequence detector. Shifts in one bit per qualified clock and emits a
//   registered one-cycle pulse whenever the last SEQ_LEN accepted bits equal the
//   programmed pattern. The pattern can be reloaded at runtime. Matches may
//   overlap or not, and a saturating counter tallies the matches.
//
// Ports
//   clk          : rising-edge clock
//   reset        : synchronous, active-high reset
//   x, x_valid   : serial bit and its qualifier
//   overlap_en   : 1 = overlapping matches, 0 = each match needs fresh bits
//   cfg_load     : load cfg_pattern (MSB = first bit received); drops that x
//   cfg_pattern  : new pattern
//   cnt_clr      : clear match_count (wins over a same-cycle increment)
//   detector_out : registered match pulse
//   match_count  : saturating match count
// -----------------------------------------------------------------------------
module seq_detector_param #(
   parameter int                 SEQ_LEN = 4,
   parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               x,
   input  logic               x_valid,
   input  logic               overlap_en,
   input  logic               cfg_load,
   input  logic [SEQ_LEN-1:0] cfg_pattern,
   input  logic               cnt_clr,
   output logic               detector_out,
   output logic [CNT_W-1:0]   match_count
);

   localparam int                 FILL_W    = $clog2(SEQ_LEN + 1);
   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(SEQ_LEN);
   localparam logic [FILL_W:0]    FILL_CMP  = (FILL_W + 1)'(SEQ_LEN);
   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

   // Only the newest SEQ_LEN-1 bits are kept: the oldest bit of the window
   // falls off on every shift, so it never takes part in a compare.
   logic [SEQ_LEN-2:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [SEQ_LEN-1:0] pat_q, pat_d;
   logic               det_q, det_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [SEQ_LEN-1:0] nxt;
   logic [FILL_W:0]    fill_inc;
   logic               match;

   always_comb begin
      hist_d   = hist_q;
      fill_d   = fill_q;
      pat_d    = pat_q;
      det_d    = 1'b0;
      cnt_d    = cnt_q;
      nxt      = {hist_q, x};
      // One bit wider so fill+1 cannot wrap before the compare.
      fill_inc = {1'b0, fill_q} + (FILL_W + 1)'(1);
      match    = 1'b0;

      if (cfg_load) begin
         // The window restarts against the new pattern; x this cycle is dropped.
         pat_d  = cfg_pattern;
         fill_d = '0;
      end else if (x_valid) begin
         hist_d = nxt[SEQ_LEN-2:0];
         match  = (nxt == pat_q) && (fill_inc >= FILL_CMP);
         if (match) begin
            det_d  = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            fill_d = overlap_en ? FILL_FULL : '0;
         end else begin
            fill_d = (fill_q == FILL_FULL) ? fill_q : fill_inc[FILL_W-1:0];
         end
      end

      if (cnt_clr) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
         pat_q  <= PATTERN;
         det_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         pat_q  <= pat_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
      end
   end

   assign detector_out = det_q;
   assign match_count  = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Two detectors share one stimulus stream: u_dut0 uses the default 1011
//   pattern with an 8-bit counter, and u_dut1 uses 1111 with a 2-bit counter
//   so that saturation is quick to reach. A behavioural model pushes the
//   expected outputs into a queue as each cycle is driven. The entry is popped
//   and compared just after the clock edge.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset, x, x_valid, overlap_en, cfg_load, cnt_clr;
   logic [3:0] cfg_pattern;
   logic       det0, det1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   always #5 clk = ~clk;

   seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_dut0 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
      .detector_out(det0), .match_count(cnt0));

   seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1111), .CNT_W(2)) u_dut1 (
      .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cnt_clr(cnt_clr),
      .detector_out(det1), .match_count(cnt1));

   typedef struct {
      bit d0;
      int c0;
      bit d1;
      int c1;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model state. Index 0 is u_dut0 and index 1 is u_dut1.
   bit [3:0] m_hist;
   int       m_fresh [2];
   bit [3:0] m_pat   [2];
   int       m_cnt   [2];
   bit       m_det   [2];
   bit [3:0] def_pat [2] = '{4'b1011, 4'b1111};
   int       cnt_max [2] = '{255, 3};

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle, push the model prediction, then pop and compare after the edge.
   task automatic step(input bit rst, input bit xv, input bit xb,
                       input bit ld = 1'b0, input bit [3:0] cp = 4'h0,
                       input bit clr = 1'b0);
      exp_t e;
      @(negedge clk);
      reset = rst; x_valid = xv; x = xb; cfg_load = ld; cfg_pattern = cp; cnt_clr = clr;
      if (rst) begin
         m_hist = '0;
         for (int d = 0; d < 2; d++) begin
            m_fresh[d] = 0; m_pat[d] = def_pat[d]; m_cnt[d] = 0; m_det[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) m_det[d] = 1'b0;
         if (ld) begin
            for (int d = 0; d < 2; d++) begin
               m_pat[d] = cp; m_fresh[d] = 0;
            end
         end else if (xv) begin
            m_hist = {m_hist[2:0], xb};
            for (int d = 0; d < 2; d++) begin
               m_fresh[d]++;
               if (m_fresh[d] >= 4 && m_hist == m_pat[d]) begin
                  m_det[d] = 1'b1;
                  if (m_cnt[d] < cnt_max[d]) m_cnt[d]++;
                  if (!overlap_en) m_fresh[d] = 0;
               end
            end
         end
         if (clr) for (int d = 0; d < 2; d++) m_cnt[d] = 0;
      end
      e.d0 = m_det[0]; e.c0 = m_cnt[0]; e.d1 = m_det[1]; e.c1 = m_cnt[1];
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("det0", int'(det0), int'(e.d0));
         chk("cnt0", int'(cnt0), e.c0);
         chk("det1", int'(det1), int'(e.d1));
         chk("cnt1", int'(cnt1), e.c1);
      end
   endtask

   task automatic bits(input bit [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b1, v[i]);
   endtask

   initial begin
      int pulses;
      reset = 1'b1; x = 1'b0; x_valid = 1'b0; overlap_en = 1'b1;
      cfg_load = 1'b0; cfg_pattern = 4'h0; cnt_clr = 1'b0;

      // Overlap: 1011011 gives pulses after bits 4 and 7.
      step(1, 1, 1); step(1, 0, 0);
      chk("reset_det0", int'(det0), 0);
      chk("reset_cnt0", int'(cnt0), 0);
      overlap_en = 1'b1;
      pulses = 0;
      for (int i = 6; i >= 0; i--) begin
         bit [6:0] s;
         s = 7'b1011011;
         step(0, 1, s[i]);
         pulses += int'(det0);
      end
      chk("ovl_pulses", pulses, 2);
      chk("ovl_cnt", int'(cnt0), 2);

      // Non-overlap: the same stream gives one match, and 10111011 gives two.
      step(1, 0, 0);
      overlap_en = 1'b0;
      bits(16'b1011011, 7);
      chk("novl_cnt_a", int'(cnt0), 1);
      step(1, 0, 0);
      bits(16'b10111011, 8);
      chk("novl_cnt_b", int'(cnt0), 2);

      // x_valid gaps: 1, gap x3, 0, 1, gap, 1.
      step(1, 0, 0);
      overlap_en = 1'b1;
      step(0, 1, 1); step(0, 0, 1); step(0, 0, 0); step(0, 0, 1);
      step(0, 1, 0); step(0, 1, 1); step(0, 0, 0);
      chk("gap_nopulse", int'(det0), 0);
      step(0, 1, 1);
      chk("gap_pulse", int'(det0), 1);

      // cfg_load to 0110 after 1,0,1. The x presented with the load is discarded.
      step(1, 0, 0);
      bits(16'b101, 3);
      step(0, 1, 1, 1'b1, 4'b0110);
      bits(16'b011, 3);
      chk("load_nopulse", int'(det0), 0);
      step(0, 1, 0);
      chk("load_pulse", int'(det0), 1);
      chk("load_cnt", int'(cnt0), 1);

      // Saturation on u_dut1 (1111, CNT_W=2), then clear during a match.
      step(1, 0, 0);
      overlap_en = 1'b1;
      bits(16'hFFFF, 7);
      chk("sat_cnt", int'(cnt1), 3);
      chk("sat_pulse", int'(det1), 1);
      step(0, 1, 1, 1'b0, 4'h0, 1'b1);
      chk("clr_cnt", int'(cnt1), 0);
      chk("clr_pulse", int'(det1), 1);

      // A mid-stream reset discards the partial history.
      bits(16'b101, 3);
      step(1, 1, 1);
      chk("rst_mid_det", int'(det0), 0);
      bits(16'b101, 3);
      chk("rst_mid_nopulse", int'(det0), 0);
      step(0, 1, 1);
      chk("rst_mid_pulse", int'(det0), 1);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         overlap_en = 1'($urandom_range(0, 1));
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
              4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
